// File: rtl/arbiter_memory_request_rr.sv
// Round-robin arbiter sharing one memory request port, with an in-order tag FIFO for response steering.
// Optional per-requester grant counters via ARBITER_MEMORY_RR_STATS_EN.
package arbiter_memory_request_rr_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  id;
        logic [47:0] addr;
    } MemoryPacketPayload;

endpackage

module arbiter_memory_request_rr
    import arbiter_memory_request_rr_pkg::*;
#(
    parameter int unsigned NUM_REQUESTORS  = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned PACKET_W        = $bits(MemoryPacketPayload)
) (
    input  logic                                ap_clk,
    input  logic                                areset_n,
    input  logic [NUM_REQUESTORS-1:0]           req_in_valid,
    input  logic [NUM_REQUESTORS*PACKET_W-1:0]  req_in_payload,
    output logic [NUM_REQUESTORS-1:0]           req_in_ready,
    output logic                                req_out_valid,
    output logic [PACKET_W-1:0]                 req_out_payload,
    input  logic                                req_out_ready,
    input  logic                                resp_in_valid,
    input  logic [PACKET_W-1:0]                 resp_in_payload,
    output logic                                resp_in_ready,
    output logic [NUM_REQUESTORS-1:0]           resp_out_valid,
    output logic [PACKET_W-1:0]                 resp_out_payload,
    input  logic [NUM_REQUESTORS-1:0]           resp_out_ready,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_count,
    output logic                                error_orphan
`ifdef ARBITER_MEMORY_RR_STATS_EN
    ,
    output logic [NUM_REQUESTORS*32-1:0]        grant_count
`endif
);

    localparam int unsigned SEL_W = $clog2(NUM_REQUESTORS);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] head_tag;
    logic             any_valid;
    logic             slot_free;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             pop;
    logic             orphan;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] tag_mem [MAX_OUTSTANDING];

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQUESTORS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQUESTORS;
            if (!any_valid && req_in_valid[idx]) begin
                any_valid = 1'b1;
                winner    = SEL_W'(idx);
            end
        end
    end

    assign slot_free  = ~req_out_valid | req_out_ready;
    assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign accept     = any_valid & slot_free & ~fifo_full;

    always_comb begin
        req_in_ready = '0;
        if (accept) begin
            req_in_ready[winner] = 1'b1;
        end
    end

    // Response steering by FIFO head; orphans are swallowed.
    assign head_tag         = tag_mem[rd_ptr];
    assign resp_out_payload = resp_in_payload;
    assign orphan           = resp_in_valid & fifo_empty;
    assign pop              = resp_in_valid & ~fifo_empty & resp_out_ready[head_tag];

    always_comb begin
        resp_out_valid = '0;
        resp_in_ready  = 1'b1;
        if (!fifo_empty) begin
            resp_in_ready = resp_out_ready[head_tag];
            if (resp_in_valid) begin
                resp_out_valid[head_tag] = 1'b1;
            end
        end
    end

    assign outstanding_count = count;

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr          <= '0;
            req_out_valid   <= 1'b0;
            req_out_payload <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            error_orphan    <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr          <= (winner == SEL_W'(NUM_REQUESTORS - 1)) ? '0 : winner + SEL_W'(1);
                req_out_valid   <= 1'b1;
                req_out_payload <= req_in_payload[32'(winner)*PACKET_W +: PACKET_W];
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end else if (req_out_ready) begin
                req_out_valid   <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!accept && pop) begin
                count <= count - CNT_W'(1);
            end
            if (orphan) begin
                error_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

`ifdef ARBITER_MEMORY_RR_STATS_EN
    logic [31:0] grant_cnt [NUM_REQUESTORS];

    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (accept && (grant_cnt[winner] != '1)) begin
            grant_cnt[winner] <= grant_cnt[winner] + 32'd1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQUESTORS; i++) begin
            grant_count[i*32 +: 32] = grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_arbiter_memory_request_rr.sv
// Bench for arbiter_memory_request_rr: queue-based reference model checked every cycle plus directed literals.
module tb_arbiter_memory_request_rr;

    localparam int unsigned N = 4;
    localparam int unsigned M = 8;
    localparam int unsigned W = 64;

    logic             ap_clk = 1'b0;
    logic             areset_n;
    logic [N-1:0]     req_in_valid;
    logic [N*W-1:0]   req_in_payload;
    logic [N-1:0]     req_in_ready;
    logic             req_out_valid;
    logic [W-1:0]     req_out_payload;
    logic             req_out_ready;
    logic             resp_in_valid;
    logic [W-1:0]     resp_in_payload;
    logic             resp_in_ready;
    logic [N-1:0]     resp_out_valid;
    logic [W-1:0]     resp_out_payload;
    logic [N-1:0]     resp_out_ready;
    logic [$clog2(M):0] outstanding_count;
    logic             error_orphan;
`ifdef ARBITER_MEMORY_RR_STATS_EN
    logic [N*32-1:0]  grant_count;
`endif

    arbiter_memory_request_rr #(
        .NUM_REQUESTORS  (N),
        .MAX_OUTSTANDING (M),
        .PACKET_W        (W)
    ) dut (
        .ap_clk            (ap_clk),
        .areset_n          (areset_n),
        .req_in_valid      (req_in_valid),
        .req_in_payload    (req_in_payload),
        .req_in_ready      (req_in_ready),
        .req_out_valid     (req_out_valid),
        .req_out_payload   (req_out_payload),
        .req_out_ready     (req_out_ready),
        .resp_in_valid     (resp_in_valid),
        .resp_in_payload   (resp_in_payload),
        .resp_in_ready     (resp_in_ready),
        .resp_out_valid    (resp_out_valid),
        .resp_out_payload  (resp_out_payload),
        .resp_out_ready    (resp_out_ready),
        .outstanding_count (outstanding_count),
        .error_orphan      (error_orphan)
`ifdef ARBITER_MEMORY_RR_STATS_EN
        ,
        .grant_count       (grant_count)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, outstanding tags as a queue, output register, sticky orphan.
    int           m_rr;
    int           q[$];
    logic         m_vld;
    logic [W-1:0] m_pay;
    logic         m_orph;
    int           grant_log[$];
    int           e_w;
    int           e_head;
    logic         e_acc;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rov;
    logic         e_rir;

    initial begin
        m_rr = 0; m_vld = 1'b0; m_pay = '0; m_orph = 1'b0;
    end

    always begin
        @(negedge ap_clk);
        if (!areset_n) begin
            m_rr = 0;
            q.delete();
            m_vld = 1'b0;
            m_pay = '0;
            m_orph = 1'b0;
        end
        e_w = -1;
        for (int k = 0; k < int'(N); k++) begin
            if (e_w < 0 && req_in_valid[(m_rr + k) % int'(N)]) e_w = (m_rr + k) % int'(N);
        end
        e_acc = (e_w >= 0) && (!m_vld || req_out_ready) && (q.size() < int'(M));
        e_rdy = '0;
        if (e_acc) e_rdy[e_w] = 1'b1;
        e_head = (q.size() > 0) ? q[0] : -1;
        e_rov = '0;
        e_rir = 1'b1;
        if (e_head >= 0) begin
            e_rir = resp_out_ready[e_head];
            if (resp_in_valid) e_rov[e_head] = 1'b1;
        end
        check("m_req_in_ready", 64'(req_in_ready), 64'(e_rdy));
        check("m_req_out_valid", 64'(req_out_valid), 64'(m_vld));
        check("m_req_out_payload", req_out_payload, m_pay);
        check("m_resp_out_valid", 64'(resp_out_valid), 64'(e_rov));
        check("m_resp_in_ready", 64'(resp_in_ready), 64'(e_rir));
        check("m_resp_out_payload", resp_out_payload, resp_in_payload);
        check("m_outstanding", 64'(outstanding_count), 64'(q.size()));
        check("m_error_orphan", 64'(error_orphan), 64'(m_orph));
        if (areset_n) begin
            if (resp_in_valid && e_head < 0) m_orph = 1'b1;
            if (resp_in_valid && e_head >= 0 && resp_out_ready[e_head]) void'(q.pop_front());
            if (e_acc) begin
                q.push_back(e_w);
                grant_log.push_back(e_w);
                m_vld = 1'b1;
                m_pay = req_in_payload[e_w*W +: W];
                m_rr  = (e_w + 1) % int'(N);
            end else if (req_out_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic set_pay(input int i, input logic [W-1:0] v);
        req_in_payload[i*W +: W] = v;
    endtask

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        areset_n        = 1'b0;
        req_in_valid    = '0;
        req_in_payload  = '0;
        req_out_ready   = 1'b1;
        resp_in_valid   = 1'b0;
        resp_in_payload = 64'h0;
        resp_out_ready  = '1;
        step(2);
        check("reset_req_out_valid", 64'(req_out_valid), 64'd0);
        check("reset_outstanding", 64'(outstanding_count), 64'd0);
        check("reset_error_orphan", 64'(error_orphan), 64'd0);
        check("reset_payload", req_out_payload, 64'd0);
        areset_n = 1'b1;

        // Fairness and credit stall
        for (int i = 0; i < int'(N); i++) set_pay(i, 64'hA0 + 64'(i));
        grant_log.delete();
        req_in_valid = '1;
        step(1);
        check("fair_first_valid", 64'(req_out_valid), 64'd1);
        step(7);
        check("fair_log_size", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_order", 64'(grant_log[i]), 64'(exp_order[i]));
        check("credit_count_full", 64'(outstanding_count), 64'd8);
        check("credit_ready_zero", 64'(req_in_ready), 64'd0);
        resp_in_valid   = 1'b1;
        resp_in_payload = 64'hFEED_0001;
        #1;
        check("credit_resp_route0", 64'(resp_out_valid), 64'b0001);
        check("credit_resp_pass", resp_out_payload, 64'hFEED_0001);
        step(1);
        resp_in_valid = 1'b0;
        #1;
        check("credit_count_7", 64'(outstanding_count), 64'd7);
        check("credit_ready_again", 64'(req_in_ready), 64'b0001);
        step(1);
        req_in_valid = '0;
        check("credit_refill", 64'(outstanding_count), 64'd8);
        resp_in_valid = 1'b1;
        step(8);
        resp_in_valid = 1'b0;
        #1;
        check("drain_empty", 64'(outstanding_count), 64'd0);

        // Routing 3,1,1 with stall on requester 3
        req_in_valid = 4'b1000;
        step(1);
        req_in_valid = 4'b0010;
        step(2);
        req_in_valid = '0;
        resp_out_ready  = 4'b0111;
        resp_in_valid   = 1'b1;
        resp_in_payload = 64'hBEEF_0003;
        #1;
        check("route_first_3", 64'(resp_out_valid), 64'b1000);
        check("route_stall", 64'(resp_in_ready), 64'd0);
        step(2);
        check("route_stall_count", 64'(outstanding_count), 64'd3);
        resp_out_ready = '1;
        #1;
        check("route_unstall", 64'(resp_in_ready), 64'd1);
        step(1);
        check("route_second_1", 64'(resp_out_valid), 64'b0010);
        step(1);
        check("route_third_1", 64'(resp_out_valid), 64'b0010);
        step(1);
        resp_in_valid = 1'b0;
        #1;
        check("route_empty", 64'(outstanding_count), 64'd0);

        // Backpressure on requester 2
        req_in_valid  = 4'b0100;
        set_pay(2, 64'h1111_1111);
        req_out_ready = 1'b0;
        step(1);
        set_pay(2, 64'h2222_2222);
        #1;
        check("bp_valid", 64'(req_out_valid), 64'd1);
        check("bp_payload", req_out_payload, 64'h1111_1111);
        check("bp_no_ready", 64'(req_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("bp_hold", req_out_payload, 64'h1111_1111);
            check("bp_hold_ready", 64'(req_in_ready), 64'd0);
        end
        req_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_in_ready), 64'b0100);
        step(1);
        req_in_valid = '0;
        check("bp_second_payload", req_out_payload, 64'h2222_2222);
        check("bp_second_valid", 64'(req_out_valid), 64'd1);
        step(1);
        check("bp_idle", 64'(req_out_valid), 64'd0);
        resp_in_valid = 1'b1;
        step(2);
        resp_in_valid = 1'b0;
        #1;
        check("bp_drained", 64'(outstanding_count), 64'd0);

        // Orphan response
        resp_out_ready = '0;
        resp_in_valid  = 1'b1;
        #1;
        check("orphan_ready", 64'(resp_in_ready), 64'd1);
        check("orphan_no_route", 64'(resp_out_valid), 64'd0);
        step(1);
        resp_in_valid = 1'b0;
        check("orphan_flag", 64'(error_orphan), 64'd1);
        step(3);
        check("orphan_sticky", 64'(error_orphan), 64'd1);
        resp_out_ready = '1;

        // Reset with five requests in flight
        req_in_valid = '1;
        step(5);
        check("rst_count5", 64'(outstanding_count), 64'd5);
        areset_n = 1'b0;
        #1;
        check("rst_valid", 64'(req_out_valid), 64'd0);
        check("rst_count", 64'(outstanding_count), 64'd0);
        check("rst_orphan", 64'(error_orphan), 64'd0);
        check("rst_payload", req_out_payload, 64'd0);
        step(1);
        areset_n = 1'b1;
        grant_log.delete();
        step(1);
        check("rst_first_grant_n", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) check("rst_first_grant", 64'(grant_log[0]), 64'd0);
        check("rst_first_payload", req_out_payload, 64'hA0);
        req_in_valid = '0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbiter_memory_request_rr.md
Name: arbiter_memory_request_rr

Overview:
- Round-robin arbiter that shares one cache/memory request port among NUM_REQUESTORS engine-side requesters.
- Every granted request's source index is recorded in an in-order tag FIFO. This FIFO bounds the number of outstanding requests and steers each returning in-order response to the requester that issued it.
- Sits between the engine bundle's MemoryPacket request streams and the cache front-end that produces CacheRequest/CacheResponse.

Parameters:
- NUM_REQUESTORS, 4: requester count, >=2.
- MAX_OUTSTANDING, 8: tag FIFO depth and in-flight limit; power of two.
- PACKET_W, $bits(MemoryPacketPayload): payload width.

Ports:
- ap_clk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- req_in_valid  in  NUM_REQUESTORS  per-requester request valid.
- req_in_payload  in  NUM_REQUESTORS*PACKET_W  per-requester payload.
- req_in_ready  out  NUM_REQUESTORS  per-requester accept.
- req_out_valid  out  1  registered request to cache.
- req_out_payload  out  PACKET_W  registered payload.
- req_out_ready  in  1  cache accepts.
- resp_in_valid  in  1  cache response valid (in order).
- resp_in_payload  in  PACKET_W  response payload.
- resp_in_ready  out  1  response consumed.
- resp_out_valid  out  NUM_REQUESTORS  routed response valid.
- resp_out_payload  out  PACKET_W  shared response payload bus.
- resp_out_ready  in  NUM_REQUESTORS  requester accepts response.
- outstanding_count  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy.
- error_orphan  out  1  sticky flag: response arrived with no outstanding tag.

Behaviour:
- Reset (async assert, sync deassert): the following all clear to 0: req_out_valid, req_out_payload, tag FIFO pointers/count, outstanding_count, error_orphan. The RR pointer resets to 0.
- Grant selection: combinational. Search from rr_ptr upward, modulo NUM_REQUESTORS; the first i with req_in_valid[i]=1 wins.
- req_in_ready[i] = (i==winner) & slot_free & ~fifo_full.
  - slot_free = ~req_out_valid | req_out_ready.
  - At most one ready bit is high per cycle.
- On accept (req_in_valid[w]&req_in_ready[w]):
  - Next cycle: req_out_valid=1, payload registered.
  - Tag w is pushed into the FIFO in the same cycle.
  - rr_ptr <= (w+1) mod NUM_REQUESTORS.
  - Accept-to-output latency is 1 cycle.
- Output register: holds payload stable while req_out_valid & ~req_out_ready. It clears when it handshakes and no new accept occurs that cycle. Back-to-back accepts give full throughput.
- Credit limit: when count==MAX_OUTSTANDING, all req_in_ready=0. No accept takes place, and rr_ptr holds.
- Response routing:
  - tag = FIFO head.
  - resp_out_valid[i] = resp_in_valid & ~fifo_empty & (tag==i).
  - resp_out_payload = resp_in_payload (combinational, zero latency).
  - resp_in_ready = ~fifo_empty & resp_out_ready[tag].
  - Pop on resp_in_valid & resp_in_ready.
- Orphan response (resp_in_valid & fifo_empty): resp_in_ready=1, the response is dropped, and error_orphan is set. error_orphan clears only on reset.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Push on full cannot occur, because the credit gate forbids it. A push and pop in the same cycle while full is not allowed: the credit check uses pre-pop count, which is conservative by one cycle.
- Reset mid-operation: in-flight requests and tags are discarded. Responses arriving after reset are orphans.
- Payload is never modified in either direction.

Optional Feature:
- Macro: ARBITER_MEMORY_RR_STATS_EN.
- Enabled: adds output port grant_count, NUM_REQUESTORS*32 bits.
  - One free-running 32-bit counter per requester, incremented on each accept.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Disabled: port and counters absent; no other behaviour change.

Test Plan:
- Fairness: all 4 requesters held valid, req_out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. req_out_valid high from cycle 1. Tag FIFO holds 0,1,2,3,0,1,2,3.
- Backpressure: requester 2 only, req_out_ready=0 for 3 cycles -> req_out_payload stable. req_in_ready[2]=0 after the first accept. Second payload issued the cycle after req_out_ready returns.
- Credit stall, MAX_OUTSTANDING=8, no responses: 8 accepts -> outstanding_count=8 and all req_in_ready=0. One response -> count 7, next accept allowed.
- Routing: issue from requesters 3,1,1 -> three responses appear on resp_out_valid[3], [1], [1] in that order. Holding resp_out_ready[3]=0 stalls resp_in_ready.
- Orphan: response with empty FIFO -> resp_in_ready=1, no resp_out_valid, error_orphan=1 until reset.
- Reset mid-flight: assert areset_n low with count=5 -> all outputs 0 immediately, rr_ptr=0. After release, requester 0 is granted first.
